// File: rtl/apb_reg_mst_bridge.sv
// APB3 completer that turns one APB transfer into a held register-master request and waits for its ack.
// Optional watchdog is compiled in with APB_REG_MST_BRIDGE_TIMEOUT_EN.
module apb_reg_mst_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  soft_rst,
  output logic                  mst_req_vld,
  input  logic                  mst_req_rdy,
  output logic                  mst_wr_en,
  output logic                  mst_rd_en,
  output logic [ADDR_WIDTH-1:0] mst_addr,
  output logic [DATA_WIDTH-1:0] mst_wr_data,
  input  logic                  mst_ack_vld,
  output logic                  mst_ack_rdy,
  input  logic [DATA_WIDTH-1:0] mst_rd_data,
  output logic                  mst_sync_reset,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   mst_addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   mst_wr_data_q, wdata_d;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic                    pready_q, pslverr_q;
  logic                    mst_req_vld_q, mst_wr_en_q, mst_rd_en_q;
  logic                    mst_ack_rdy_q, mst_sync_reset_q;
  logic                    capture, ack_hit, abort, wd_limit, wd_fire;

  // Handshakes: a beat transfers on a cycle where valid and ready are both high.
  // req_vld is held with a stable payload until req_rdy; ack_rdy is high in REQ and
  // WAIT_ACK only, so an ack_vld seen in IDLE or DONE never transfers.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    ack_hit = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = REQ;
          capture = 1'b1;
        end
      end
      REQ: begin
        if (mst_req_rdy && mst_ack_vld) begin
          state_d = DONE;
          ack_hit = 1'b1;
        end else if (soft_rst || wd_limit) begin
          state_d = DONE;
          abort   = 1'b1;
        end else if (mst_req_rdy) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (mst_ack_vld) begin
          state_d = DONE;
          ack_hit = 1'b1;
        end else if (soft_rst || wd_limit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wd_fire  = abort && wd_limit;
  // The request payload registers double as the APB latches while in REQ.
  assign pwrite_d = capture ? pwrite : pwrite_q;
  assign addr_d   = capture ? paddr  : mst_addr_q;
  assign wdata_d  = capture ? pwdata : mst_wr_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      pwrite_q         <= 1'b0;
      mst_addr_q       <= '0;
      mst_wr_data_q    <= '0;
      prdata_q         <= '0;
      pready_q         <= 1'b0;
      pslverr_q        <= 1'b0;
      mst_req_vld_q    <= 1'b0;
      mst_wr_en_q      <= 1'b0;
      mst_rd_en_q      <= 1'b0;
      mst_ack_rdy_q    <= 1'b0;
      mst_sync_reset_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pwrite_q         <= pwrite_d;
      mst_req_vld_q    <= (state_d == REQ);
      mst_wr_en_q      <= (state_d == REQ) && pwrite_d;
      mst_rd_en_q      <= (state_d == REQ) && !pwrite_d;
      mst_addr_q       <= (state_d == REQ) ? addr_d  : '0;
      mst_wr_data_q    <= (state_d == REQ) ? wdata_d : '0;
      mst_ack_rdy_q    <= (state_d == REQ) || (state_d == WAIT_ACK);
      pready_q         <= (state_d == DONE);
      pslverr_q        <= abort;
      prdata_q         <= (ack_hit && !pwrite_q) ? mst_rd_data : '0;
      mst_sync_reset_q <= soft_rst || wd_fire;
    end
  end

`ifdef APB_REG_MST_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;

  // Cleared while idle so every transfer starts counting from zero on REQ entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == REQ) || (state_q == WAIT_ACK)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign wd_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
  assign wd_limit           = 1'b0;
`endif

  assign prdata         = prdata_q;
  assign pready         = pready_q;
  assign pslverr        = pslverr_q;
  assign mst_req_vld    = mst_req_vld_q;
  assign mst_wr_en      = mst_wr_en_q;
  assign mst_rd_en      = mst_rd_en_q;
  assign mst_addr       = mst_addr_q;
  assign mst_wr_data    = mst_wr_data_q;
  assign mst_ack_rdy    = mst_ack_rdy_q;
  assign mst_sync_reset = mst_sync_reset_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_apb_reg_mst_bridge.sv
// Self-checking bench for apb_reg_mst_bridge; responses are checked against an expected queue.
// Runs the watchdog scenario when APB_REG_MST_BRIDGE_TIMEOUT_EN is defined, else the long-wait scenario.
module tb_apb_reg_mst_bridge;
  localparam int AW     = 64;
  localparam int DW     = 32;
  localparam int TO     = 16;
  localparam int OUTS_W = 2 * DW + AW + 9;

  logic          clk = 1'b0;
  logic          rstn;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr, soft_rst;
  logic          mst_req_vld, mst_req_rdy, mst_wr_en, mst_rd_en;
  logic [AW-1:0] mst_addr;
  logic [DW-1:0] mst_wr_data, mst_rd_data;
  logic          mst_ack_vld, mst_ack_rdy, mst_sync_reset;
  logic [1:0]    dbg_state;
  logic [OUTS_W-1:0] all_outs;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   exp_v;

  apb_reg_mst_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .soft_rst(soft_rst),
    .mst_req_vld(mst_req_vld), .mst_req_rdy(mst_req_rdy),
    .mst_wr_en(mst_wr_en), .mst_rd_en(mst_rd_en), .mst_addr(mst_addr), .mst_wr_data(mst_wr_data),
    .mst_ack_vld(mst_ack_vld), .mst_ack_rdy(mst_ack_rdy), .mst_rd_data(mst_rd_data),
    .mst_sync_reset(mst_sync_reset),
    .dbg_state_o(dbg_state)
  );

  assign all_outs = {prdata, pready, pslverr, mst_req_vld, mst_wr_en, mst_rd_en,
                     mst_addr, mst_wr_data, mst_ack_rdy, mst_sync_reset, dbg_state};

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t required < 2000000", $time);
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    soft_rst = 1'b0; mst_req_rdy = 1'b0; mst_ack_vld = 1'b0; mst_rd_data = '0;
  endtask

  task automatic apb_setup(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
  endtask

  task automatic end_access();
    psel = 1'b0; penable = 1'b0;
    step();
  endtask

  // Scenarios
  task automatic test_reset();
    drive_idle();
    rstn = 1'b0;
    step(); step();
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", all_outs);
    end
    rstn = 1'b1;
    step();
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h required 0", all_outs);
    end
  endtask

  task automatic test_write_fast();
    exp_q.push_back({1'b0, 32'h0});
    apb_setup(1'b1, 64'h10, 32'hDEADBEEF);
    n_checks++;
    if ({mst_req_vld, mst_wr_en, mst_rd_en, mst_ack_rdy} !== 4'b1101) begin
      n_fail++; $display("FAIL wr_fast_ctrl: got %b required 1101", {mst_req_vld, mst_wr_en, mst_rd_en, mst_ack_rdy});
    end
    n_checks++;
    if ({mst_addr, mst_wr_data} !== {64'h10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_fast_payload: got %h/%h required 10/deadbeef", mst_addr, mst_wr_data);
    end
    mst_req_rdy = 1'b1; mst_ack_vld = 1'b1; mst_rd_data = $urandom;
    step();
    mst_req_rdy = 1'b0; mst_ack_vld = 1'b0;
    n_checks++;
    if ({pready, mst_req_vld} !== 2'b10) begin
      n_fail++; $display("FAIL wr_fast_pready: got pready=%b req_vld=%b required 1/0", pready, mst_req_vld);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL wr_fast_resp: got response with empty expected queue");
    end else begin
      exp_v = exp_q.pop_front();
      if ({pslverr, prdata} !== exp_v) begin
        n_fail++; $display("FAIL wr_fast_resp: got %h required %h", {pslverr, prdata}, exp_v);
      end
    end
    end_access();
    n_checks++;
    if ({pready, dbg_state} !== 3'b000) begin
      n_fail++; $display("FAIL wr_fast_one_cycle: got pready=%b state=%0d required 0/0", pready, dbg_state);
    end
  endtask

  task automatic test_read_stall();
    logic [DW-1:0] wd;
    wd = $urandom;
    exp_q.push_back({1'b0, 32'h12345678});
    apb_setup(1'b0, 64'h20, wd);
    for (int i = 0; i < 4; i++) begin
      mst_req_rdy = (i == 3);
      n_checks++;
      if ({pready, mst_req_vld, mst_rd_en, mst_wr_en, mst_addr, mst_wr_data} !== {1'b0, 1'b1, 1'b1, 1'b0, 64'h20, wd}) begin
        n_fail++; $display("FAIL rd_stall_hold[%0d]: got vld=%b rd=%b addr=%h wd=%h required 1/1/20/%h",
                           i, mst_req_vld, mst_rd_en, mst_addr, mst_wr_data, wd);
      end
      step();
    end
    mst_req_rdy = 1'b0;
    n_checks++;
    if ({mst_req_vld, mst_addr, mst_ack_rdy, dbg_state} !== {1'b0, 64'h0, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL rd_stall_wait: got vld=%b addr=%h ack_rdy=%b state=%0d required 0/0/1/2",
                         mst_req_vld, mst_addr, mst_ack_rdy, dbg_state);
    end
    step();
    mst_ack_vld = 1'b1; mst_rd_data = 32'h12345678;
    step();
    mst_ack_vld = 1'b0; mst_rd_data = '0;
    n_checks++;
    if (pready !== 1'b1) begin
      n_fail++; $display("FAIL rd_stall_pready: got %b required 1", pready);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL rd_stall_resp: got response with empty expected queue");
    end else begin
      exp_v = exp_q.pop_front();
      if ({pslverr, prdata} !== exp_v) begin
        n_fail++; $display("FAIL rd_stall_resp: got %h required %h", {pslverr, prdata}, exp_v);
      end
    end
    end_access();
  endtask

  task automatic test_soft_rst_abort();
    exp_q.push_back({1'b1, 32'h0});
    apb_setup(1'b0, 64'h30, 32'h0);
    mst_req_rdy = 1'b1;
    step();
    mst_req_rdy = 1'b0;
    n_checks++;
    if (dbg_state !== 2'd2) begin
      n_fail++; $display("FAIL abort_in_wait: got state %0d required 2", dbg_state);
    end
    soft_rst = 1'b1; mst_rd_data = $urandom;
    step();
    soft_rst = 1'b0;
    n_checks++;
    if ({pready, pslverr, mst_sync_reset} !== 3'b111) begin
      n_fail++; $display("FAIL abort_flags: got %b required 111", {pready, pslverr, mst_sync_reset});
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL abort_resp: got response with empty expected queue");
    end else begin
      exp_v = exp_q.pop_front();
      if ({pslverr, prdata} !== exp_v) begin
        n_fail++; $display("FAIL abort_resp: got %h required %h", {pslverr, prdata}, exp_v);
      end
    end
    end_access();
    n_checks++;
    if ({pready, mst_sync_reset, dbg_state} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_release: got %b required 0000", {pready, mst_sync_reset, dbg_state});
    end
    mst_ack_vld = 1'b1; mst_rd_data = 32'hA5A5A5A5;
    step();
    mst_ack_vld = 1'b0; mst_rd_data = '0;
    n_checks++;
    if ({pready, pslverr, prdata, mst_req_vld, dbg_state} !== '0) begin
      n_fail++; $display("FAIL stray_ack: got pready=%b err=%b prdata=%h state=%0d required all 0",
                         pready, pslverr, prdata, dbg_state);
    end
  endtask

  task automatic test_reset_mid_req();
    apb_setup(1'b1, 64'h40, 32'h0BADF00D);
    n_checks++;
    if ({mst_req_vld, dbg_state} !== 3'b101) begin
      n_fail++; $display("FAIL mid_req_entry: got vld=%b state=%0d required 1/1", mst_req_vld, dbg_state);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL mid_req_async_reset: got %h required 0", all_outs);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL mid_req_held_reset: got %h required 0", all_outs);
    end
    exp_q.push_back({1'b0, 32'h00000077});
    apb_setup(1'b0, 64'h44, 32'h0);
    n_checks++;
    if ({mst_req_vld, mst_rd_en, mst_addr} !== {1'b1, 1'b1, 64'h44}) begin
      n_fail++; $display("FAIL post_reset_req: got vld=%b rd=%b addr=%h required 1/1/44", mst_req_vld, mst_rd_en, mst_addr);
    end
    mst_req_rdy = 1'b1; mst_ack_vld = 1'b1; mst_rd_data = 32'h77;
    step();
    mst_req_rdy = 1'b0; mst_ack_vld = 1'b0; mst_rd_data = '0;
    n_checks++;
    if (exp_q.size() == 0 || pready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_resp: got pready=%b queue=%0d required 1/nonempty", pready, exp_q.size());
    end else begin
      exp_v = exp_q.pop_front();
      if ({pslverr, prdata} !== exp_v) begin
        n_fail++; $display("FAIL post_reset_resp: got %h required %h", {pslverr, prdata}, exp_v);
      end
    end
    end_access();
  endtask

  task automatic test_back_to_back();
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    int            s, d;
    for (int t = 0; t < 10; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      wd = $urandom;
      rd = $urandom;
      s  = $urandom_range(0, 3);
      d  = $urandom_range(0, 3);
      exp_q.push_back({1'b0, (wr ? 32'h0 : rd)});
      apb_setup(wr, a, wd);
      for (int i = 0; i <= s; i++) begin
        mst_req_rdy = (i == s);
        mst_ack_vld = (i == s) && (d == 0);
        mst_rd_data = rd;
        n_checks++;
        if ({pready, mst_req_vld, mst_wr_en, mst_rd_en, mst_addr, mst_wr_data} !== {1'b0, 1'b1, wr, !wr, a, wd}) begin
          n_fail++; $display("FAIL b2b_req[%0d.%0d]: got vld=%b wr=%b rd=%b addr=%h wd=%h required 1/%b/%b/%h/%h",
                             t, i, mst_req_vld, mst_wr_en, mst_rd_en, mst_addr, mst_wr_data, wr, !wr, a, wd);
        end
        step();
      end
      mst_req_rdy = 1'b0;
      for (int i = 1; i <= d; i++) begin
        mst_ack_vld = (i == d);
        n_checks++;
        if ({pready, mst_req_vld, dbg_state} !== 4'b0010) begin
          n_fail++; $display("FAIL b2b_wait[%0d.%0d]: got pready=%b vld=%b state=%0d required 0/0/2",
                             t, i, pready, mst_req_vld, dbg_state);
        end
        step();
      end
      mst_ack_vld = 1'b0; mst_rd_data = '0;
      n_checks++;
      if (pready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_pready[%0d]: got %b required 1 (s=%0d d=%0d)", t, pready, s, d);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_resp[%0d]: got response with empty expected queue", t);
      end else begin
        exp_v = exp_q.pop_front();
        if ({pslverr, prdata} !== exp_v) begin
          n_fail++; $display("FAIL b2b_resp[%0d]: got %h required %h", t, {pslverr, prdata}, exp_v);
        end
      end
      end_access();
    end
  endtask

`ifdef APB_REG_MST_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    logic [DW-1:0] rd;
    exp_q.push_back({1'b1, 32'h0});
    apb_setup(1'b0, 64'h50, 32'h0);
    mst_req_rdy = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      step();
      mst_req_rdy = 1'b0;
      if (k < TO) begin
        n_checks++;
        if ({pready, mst_sync_reset} !== 2'b00) begin
          n_fail++; $display("FAIL wd_early[%0d]: got pready=%b sync=%b required 0/0", k, pready, mst_sync_reset);
        end
      end
    end
    n_checks++;
    if ({pready, pslverr, mst_sync_reset} !== 3'b111) begin
      n_fail++; $display("FAIL wd_fire: got %b required 111", {pready, pslverr, mst_sync_reset});
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL wd_resp: got response with empty expected queue");
    end else begin
      exp_v = exp_q.pop_front();
      if ({pslverr, prdata} !== exp_v) begin
        n_fail++; $display("FAIL wd_resp: got %h required %h", {pslverr, prdata}, exp_v);
      end
    end
    end_access();
    n_checks++;
    if ({pready, mst_sync_reset} !== 2'b00) begin
      n_fail++; $display("FAIL wd_one_cycle: got pready=%b sync=%b required 0/0", pready, mst_sync_reset);
    end
    rd = $urandom;
    exp_q.push_back({1'b0, rd});
    apb_setup(1'b0, 64'h54, 32'h0);
    mst_req_rdy = 1'b1;
    for (int k = 1; k < TO; k++) begin
      step();
      mst_req_rdy = 1'b0;
      n_checks++;
      if (pready !== 1'b0) begin
        n_fail++; $display("FAIL wd_limit_early[%0d]: got pready=%b required 0", k, pready);
      end
    end
    mst_ack_vld = 1'b1; mst_rd_data = rd;
    step();
    mst_ack_vld = 1'b0; mst_rd_data = '0;
    n_checks++;
    if ({pready, pslverr, mst_sync_reset} !== 3'b100) begin
      n_fail++; $display("FAIL wd_ack_wins: got %b required 100", {pready, pslverr, mst_sync_reset});
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL wd_ack_resp: got response with empty expected queue");
    end else begin
      exp_v = exp_q.pop_front();
      if ({pslverr, prdata} !== exp_v) begin
        n_fail++; $display("FAIL wd_ack_resp: got %h required %h", {pslverr, prdata}, exp_v);
      end
    end
    end_access();
  endtask
`else
  task automatic test_long_wait();
    logic [DW-1:0] rd;
    bit            early;
    rd    = $urandom;
    early = 1'b0;
    exp_q.push_back({1'b0, rd});
    apb_setup(1'b0, 64'h60, 32'h0);
    mst_req_rdy = 1'b1;
    step();
    mst_req_rdy = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (pready || pslverr || mst_sync_reset) early = 1'b1;
      step();
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++; $display("FAIL long_wait_early: got early completion=%b required 0", early);
    end
    mst_ack_vld = 1'b1; mst_rd_data = rd;
    step();
    mst_ack_vld = 1'b0; mst_rd_data = '0;
    n_checks++;
    if (pready !== 1'b1) begin
      n_fail++; $display("FAIL long_wait_pready: got %b required 1", pready);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL long_wait_resp: got response with empty expected queue");
    end else begin
      exp_v = exp_q.pop_front();
      if ({pslverr, prdata} !== exp_v) begin
        n_fail++; $display("FAIL long_wait_resp: got %h required %h", {pslverr, prdata}, exp_v);
      end
    end
    end_access();
  endtask
`endif

  // Sequence and final report
  initial begin
    test_reset();
    test_write_fast();
    test_read_stall();
    test_soft_rst_abort();
    test_reset_mid_req();
    test_back_to_back();
`ifdef APB_REG_MST_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
